ps2_dir_control: RTL and testbench

Receives PS/2 keyboard frames and decodes arrow-key and WASD make codes into a snake direction. It commits that direction only on the snake step pulse, and never allows a 180° reversal. The block sits directly upstream of `move`: its `dir` output replaces the constant direction currently driven into `move`. It runs in the 75 MHz pixel/game clock domain.

---
 rtl/ps2_dir_control.sv | 175 +++++++++++++++++
 tb/tb_ps2_dir_control.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_dir_control.sv
// PS/2 keyboard receiver that turns arrow/WASD make codes into a snake direction,
// committed only on the game step pulse and never reversing 180 degrees.
module ps2_dir_control #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 75_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       step,
    output logic [1:0] dir,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           filt_q, fall_q;
    logic [FCW-1:0] fcnt_q;

    state_t         state_q;
    logic [2:0]     bitcnt_q;
    logic [7:0]     shift_q;
    logic           par_q;
    logic [TW-1:0]  tmo_q;
    logic           ext_q, brk_q;
    logic [1:0]     pending_q, dir_q;
    logic           pending_v_q, key_valid_q, frame_err_q;

    logic           make_v_d;
    logic [1:0]     make_dir_d;

    // Synchronize, then accept a ps2_clk level only after FILTER_LEN agreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
            fall_q   <= 1'b0;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
            fall_q   <= 1'b0;
            if (clk_s2_q == filt_q) begin
                fcnt_q <= '0;
            end else if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_q <= clk_s2_q;
                fcnt_q <= '0;
                fall_q <= filt_q;
            end else begin
                fcnt_q <= fcnt_q + FCW'(1);
            end
        end
    end

    always_comb begin
        make_v_d   = 1'b1;
        make_dir_d = 2'd0;
        if (ext_q) begin
            case (shift_q)
                8'h75:   make_dir_d = 2'd0;
                8'h72:   make_dir_d = 2'd1;
                8'h6B:   make_dir_d = 2'd2;
                8'h74:   make_dir_d = 2'd3;
                default: make_v_d   = 1'b0;
            endcase
        end else begin
            case (shift_q)
                8'h1D:   make_dir_d = 2'd0;
                8'h1B:   make_dir_d = 2'd1;
                8'h1C:   make_dir_d = 2'd2;
                8'h23:   make_dir_d = 2'd3;
                default: make_v_d   = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            pending_q   <= 2'd0;
            pending_v_q <= 1'b0;
            dir_q       <= 2'd2;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;

            // Opposite directions differ only in bit 0; a fresh make code below overrides the clear.
            if (step) begin
                if (pending_v_q && (pending_q != (dir_q ^ 2'b01)))
                    dir_q <= pending_q;
                pending_v_q <= 1'b0;
            end

            if (state_q == S_IDLE || fall_q)
                tmo_q <= '0;
            else
                tmo_q <= tmo_q + TW'(1);

            case (state_q)
                S_IDLE: begin
                    if (fall_q && !dat_s2_q) begin
                        state_q  <= S_DATA;
                        bitcnt_q <= '0;
                    end
                end
                S_DATA: begin
                    if (fall_q) begin
                        shift_q  <= {dat_s2_q, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7)
                            state_q <= S_PARITY;
                    end
                end
                S_PARITY: begin
                    if (fall_q) begin
                        par_q   <= dat_s2_q;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (fall_q) begin
                        state_q <= S_IDLE;
                        if ((^{shift_q, par_q}) && dat_s2_q) begin
                            if (shift_q == 8'hE0) begin
                                ext_q <= 1'b1;
                            end else if (shift_q == 8'hF0) begin
                                brk_q <= 1'b1;
                            end else begin
                                if (!brk_q && make_v_d) begin
                                    pending_q   <= make_dir_d;
                                    pending_v_q <= 1'b1;
                                    key_valid_q <= 1'b1;
                                end
                                ext_q <= 1'b0;
                                brk_q <= 1'b0;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (state_q != S_IDLE && !fall_q && tmo_q == TW'(TIMEOUT - 1)) begin
                state_q     <= S_IDLE;
                frame_err_q <= 1'b1;
            end
        end
    end

    assign dir       = dir_q;
    assign key_valid = key_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_dir_control.sv
// Bench for ps2_dir_control: directed scenarios plus random key streams against a key-level model.
module tb_ps2_dir_control;

    localparam int H   = 20;
    localparam int TMO = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       step = 1'b0;
    logic [1:0] dir;
    logic       key_valid, frame_err;

    always #5 clk = ~clk;

    ps2_dir_control #(.FILTER_LEN(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .step(step), .dir(dir), .key_valid(key_valid), .frame_err(frame_err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int kv_cnt  = 0;
    int fe_cnt  = 0;

    always @(negedge clk) begin
        if (key_valid) kv_cnt++;
        if (frame_err) fe_cnt++;
    end

    // Key-level model state
    bit m_ext, m_brk, m_pv;
    int m_pend, m_dir, m_kv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int map_code(input bit ext, input logic [7:0] b);
        if (ext) begin
            case (b)
                8'h75: return 0;
                8'h72: return 1;
                8'h6B: return 2;
                8'h74: return 3;
                default: return -1;
            endcase
        end
        case (b)
            8'h1D: return 0;
            8'h1B: return 1;
            8'h1C: return 2;
            8'h23: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int opposite(input int d);
        case (d)
            0: return 1;
            1: return 0;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_pv = 0; m_pend = 0; m_dir = 2;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int d;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            d = m_brk ? -1 : map_code(m_ext, b);
            if (d >= 0) begin
                m_pend = d; m_pv = 1; m_kv++;
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic model_step();
        if (m_pv && m_pend != opposite(m_dir)) m_dir = m_pend;
        m_pv = 0;
    endtask

    task automatic send_bits(input logic [10:0] fr, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = fr[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int kv0, fe0, mkv0;
        kv0 = kv_cnt; fe0 = fe_cnt; mkv0 = m_kv;
        send_bits(frame(b, bad_par, bad_stop), 11);
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
        if (!bad_par && !bad_stop) model_byte(b);
        chk($sformatf("key_valid count byte %02h", b), kv_cnt - kv0, m_kv - mkv0);
        chk($sformatf("frame_err count byte %02h", b), fe_cnt - fe0, (bad_par || bad_stop) ? 1 : 0);
    endtask

    task automatic do_step(input int width);
        @(negedge clk);
        step = 1'b1;
        for (int i = 0; i < width; i++) begin
            model_step();
            @(negedge clk);
        end
        step = 1'b0;
        @(negedge clk);
        chk("dir after step", dir, m_dir);
    endtask

    logic [7:0] pool [12] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                              8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h12, 8'h5A};

    initial begin
        int fe0;
        int idx, pick;
        bit err;
        model_reset();
        m_kv = 0;
        repeat (5) @(negedge clk);
        chk("reset dir", dir, 2);
        chk("reset key_valid", key_valid, 0);
        chk("reset frame_err", frame_err, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        send_byte(8'hE0, 0, 0);
        send_byte(8'h74, 0, 0);
        do_step(1);
        chk("reversal rejected", dir, 2);
        do_step(1);
        chk("idle step holds", dir, 2);

        send_byte(8'hE0, 0, 0);
        send_byte(8'h75, 0, 0);
        do_step(1);
        chk("up committed", dir, 0);

        send_byte(8'h1D, 0, 0);
        send_byte(8'h23, 0, 0);
        do_step(1);
        chk("last key wins", dir, 3);

        send_byte(8'hE0, 0, 0);
        send_byte(8'hF0, 0, 0);
        send_byte(8'h75, 0, 0);
        send_byte(8'h75, 0, 0);
        do_step(1);
        chk("break ignored", dir, 3);

        send_byte(8'h1D, 1, 0);
        send_byte(8'h1B, 0, 1);

        fe0 = fe_cnt;
        send_bits(frame(8'h1C, 0, 0), 5);
        ps2_data = 1'b1;
        repeat (TMO + 200) @(negedge clk);
        chk("timeout frame_err", fe_cnt - fe0, 1);
        send_byte(8'h1D, 0, 0);
        do_step(1);
        chk("decode after timeout", dir, 0);

        ps2_data = 1'b0;
        repeat (6) begin
            ps2_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (12) @(negedge clk);
        end
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
        send_byte(8'h23, 0, 0);
        do_step(1);
        chk("decode after glitches", dir, 3);

        send_bits(frame(8'h1C, 0, 0), 5);
        ps2_data = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid-frame reset dir", dir, 2);
        chk("mid-frame reset key_valid", key_valid, 0);
        model_reset();
        rst = 1'b1;
        repeat (H) @(negedge clk);
        send_byte(8'hE0, 0, 0);
        send_byte(8'h72, 0, 0);
        do_step(1);
        chk("decode after reset", dir, 1);

        for (int it = 0; it < 40; it++) begin
            idx  = $urandom_range(0, 11);
            err  = ($urandom_range(0, 9) == 0);
            pick = $urandom_range(0, 1);
            send_byte(pool[idx], err && pick == 0, err && pick == 1);
            if ($urandom_range(0, 2) == 0) do_step($urandom_range(1, 2));
        end
        do_step(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
